// File: rtl/conv_mem_host.sv
// conv_mem_host: memory-side responder for the convolution/max-pool accelerator.
// Holds the 64x64 input image and the layer-0 (64x64) and layer-1 (32x32) result
// memories. It serves accelerator reads and writes, runs the ready/busy handshake,
// and gives the host a load port, a readback port, write statistics and error flags.
module conv_mem_host #(
  parameter int unsigned DW      = 20,
  parameter int unsigned IMG_AW  = 12,
  parameter int unsigned L1_AW   = 10,
  parameter int unsigned TIMEOUT = 200000
) (
  input  logic              clk,
  input  logic              reset,
  // host side
  input  logic              ld_valid,
  input  logic [IMG_AW-1:0] ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic              start,
  input  logic [2:0]        rb_sel,
  input  logic [IMG_AW-1:0] rb_addr,
  output logic [DW-1:0]     rb_data,
  output logic              done,
  output logic              timeout_err,
  output logic              sel_err,
  output logic [IMG_AW:0]   wr_cnt_l0,
  output logic [L1_AW:0]    wr_cnt_l1,
  // accelerator side
  output logic              ready,
  input  logic              busy,
  input  logic [IMG_AW-1:0] iaddr,
  output logic [DW-1:0]     idata,
  input  logic              cwr,
  input  logic [IMG_AW-1:0] caddr_wr,
  input  logic [DW-1:0]     cdata_wr,
  input  logic              crd,
  input  logic [IMG_AW-1:0] caddr_rd,
  output logic [DW-1:0]     cdata_rd,
  input  logic [2:0]        csel
);

  localparam int unsigned TW       = $clog2(TIMEOUT + 1);
  localparam logic [2:0]  CSEL_L0  = 3'b001;
  localparam logic [2:0]  CSEL_L1  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                ready_q, done_q;
  logic                timeout_err_q, sel_err_q;
  logic [TW-1:0]       tmo_q;
  logic [IMG_AW:0]     cnt_l0_q;
  logic [L1_AW:0]      cnt_l1_q;
  logic [DW-1:0]       rb_q;

  logic [DW-1:0] img_mem [0:(1 << IMG_AW) - 1];
  logic [DW-1:0] l0_mem  [0:(1 << IMG_AW) - 1];
  logic [DW-1:0] l1_mem  [0:(1 << L1_AW) - 1];

  logic active, host_phase, arm_entry, tmo_hit;
  logic l0_wr_ok, l1_wr_ok, wr_bad, rd_bad;
  logic rd_l0, rd_l1;

  // Access decode shared by the FSM, memory write and read paths
  always_comb begin
    active     = (state_q == ARM) || (state_q == RUN);
    host_phase = (state_q == IDLE) || (state_q == DONE);
    arm_entry  = host_phase && start;
    tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));
    l0_wr_ok   = active && cwr && (csel == CSEL_L0);
    l1_wr_ok   = active && cwr && (csel == CSEL_L1) && (caddr_wr[IMG_AW-1:L1_AW] == '0);
    wr_bad     = active && cwr && !(csel == CSEL_L0) && !l1_wr_ok;
    rd_l0      = crd && (csel == CSEL_L0);
    rd_l1      = crd && (csel == CSEL_L1) && (caddr_rd[IMG_AW-1:L1_AW] == '0);
    rd_bad     = active && crd && !rd_l0 && !rd_l1;
  end

  // Next-state logic; a timeout wins over a simultaneous busy fall
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = ARM;
      ARM:  if (tmo_hit) state_d = DONE;
            else if (busy) state_d = RUN;
      RUN:  if (tmo_hit || !busy) state_d = DONE;
      DONE: if (start) state_d = ARM;
      default: state_d = IDLE;
    endcase
  end

  // Handshake FSM with registered outputs, timeout, sticky errors and write counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
      sel_err_q     <= 1'b0;
      cnt_l0_q      <= '0;
      cnt_l1_q      <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ARM);
      done_q  <= (state_d == DONE);
      if (arm_entry) begin
        tmo_q         <= '0;
        timeout_err_q <= 1'b0;
        sel_err_q     <= 1'b0;
        cnt_l0_q      <= '0;
        cnt_l1_q      <= '0;
      end else if (active) begin
        tmo_q <= tmo_q + 1'b1;
        if (tmo_hit) timeout_err_q <= 1'b1;
        if (wr_bad || rd_bad) sel_err_q <= 1'b1;
        if (l0_wr_ok && (cnt_l0_q != '1)) cnt_l0_q <= cnt_l0_q + 1'b1;
        if (l1_wr_ok && (cnt_l1_q != '1)) cnt_l1_q <= cnt_l1_q + 1'b1;
      end
    end
  end

  // Host image load, accepted only while the accelerator is not running
  always_ff @(posedge clk) begin
    if (ld_valid && host_phase) img_mem[ld_addr] <= ld_data;
  end

  // Accelerator layer writes; arrays are deliberately not reset
  always_ff @(posedge clk) begin
    if (l0_wr_ok) l0_mem[caddr_wr] <= cdata_wr;
    if (l1_wr_ok) l1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
  end

  // Combinational accelerator reads; illegal selects read as zero
  always_comb begin
    idata    = img_mem[iaddr];
    cdata_rd = '0;
    if (rd_l0)      cdata_rd = l0_mem[caddr_rd];
    else if (rd_l1) cdata_rd = l1_mem[caddr_rd[L1_AW-1:0]];
  end

  // Registered host readback of any memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_q <= '0;
    end else begin
      case (rb_sel)
        CSEL_L0: rb_q <= l0_mem[rb_addr];
        CSEL_L1: rb_q <= l1_mem[rb_addr[L1_AW-1:0]];
        default: rb_q <= img_mem[rb_addr];
      endcase
    end
  end

  // Output mapping
  always_comb begin
    ready       = ready_q;
    done        = done_q;
    timeout_err = timeout_err_q;
    sel_err     = sel_err_q;
    wr_cnt_l0   = cnt_l0_q;
    wr_cnt_l1   = cnt_l1_q;
    rb_data     = rb_q;
  end

endmodule

// File: tb/tb_conv_mem_host.sv
// tb_conv_mem_host: directed self-checking bench for conv_mem_host.
module tb_conv_mem_host;

  localparam int unsigned TO = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [11:0] ld_addr;
  logic [19:0] ld_data;
  logic        start;
  logic [2:0]  rb_sel;
  logic [11:0] rb_addr;
  logic [19:0] rb_data;
  logic        done, timeout_err, sel_err;
  logic [12:0] wr_cnt_l0;
  logic [10:0] wr_cnt_l1;
  logic        ready, busy;
  logic [11:0] iaddr;
  logic [19:0] idata;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic [2:0]  csel;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    string       tag;
    logic [19:0] exp;
  } rb_exp_t;
  rb_exp_t rbq[$];

  conv_mem_host #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data),
    .done(done), .timeout_err(timeout_err), .sel_err(sel_err),
    .wr_cnt_l0(wr_cnt_l0), .wr_cnt_l1(wr_cnt_l1),
    .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of run, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rb_push(input string tag, input logic [2:0] sel, input logic [11:0] a,
                         input logic [19:0] exp);
    rb_exp_t e;
    rb_sel  = sel;
    rb_addr = a;
    e.tag   = tag;
    e.exp   = exp;
    rbq.push_back(e);
  endtask

  task automatic rb_pop();
    rb_exp_t e;
    if (rbq.size() == 0) begin
      chk("rb_queue_empty", 32'd0, 32'd1);
    end else begin
      e = rbq.pop_front();
      chk(e.tag, {12'd0, rb_data}, {12'd0, e.exp});
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_ready"}, {31'd0, ready}, 32'd0);
    chk({pfx, "_done"}, {31'd0, done}, 32'd0);
    chk({pfx, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    chk({pfx, "_sel_err"}, {31'd0, sel_err}, 32'd0);
    chk({pfx, "_wr_cnt_l0"}, {19'd0, wr_cnt_l0}, 32'd0);
    chk({pfx, "_wr_cnt_l1"}, {21'd0, wr_cnt_l1}, 32'd0);
    chk({pfx, "_rb_data"}, {12'd0, rb_data}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
    rb_sel = 3'b000; rb_addr = '0; busy = 1'b0; iaddr = '0;
    cwr = 1'b0; caddr_wr = '0; cdata_wr = '0; crd = 1'b0; caddr_rd = '0; csel = 3'b000;
    repeat (3) tick();
    chk_reset_outputs("por");
    reset = 1'b0;
    tick();

    // load img[a] = a; the final load coincides with start and must still commit
    for (int a = 0; a < 4096; a++) begin
      ld_valid = 1'b1;
      ld_addr  = 12'(a);
      ld_data  = 20'(a);
      start    = (a == 4095);
      tick();
    end
    ld_valid = 1'b0;
    start    = 1'b0;
    chk("ready_after_start", {31'd0, ready}, 32'd1);
    chk("done_in_arm", {31'd0, done}, 32'd0);
    iaddr = 12'd4095; #1;
    chk("idata_load_with_start", {12'd0, idata}, 32'd4095);
    iaddr = 12'd130; #1;
    chk("idata_130", {12'd0, idata}, 32'd130);

    // load attempt in ARM is ignored
    ld_valid = 1'b1; ld_addr = 12'd5; ld_data = 20'hFFFFF;
    tick();
    ld_valid = 1'b0;
    iaddr = 12'd5; #1;
    chk("load_ignored_in_arm", {12'd0, idata}, 32'd5);

    // busy high moves to RUN and drops ready
    busy = 1'b1;
    tick();
    chk("ready_fall_on_busy", {31'd0, ready}, 32'd0);

    // L0 write, then readback via crd
    cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd4095; cdata_wr = 20'h12345;
    tick();
    crd = 1'b1; caddr_rd = 12'd4095;
    cdata_wr = 20'h54321; #1;
    chk("l0_read_after_write", {12'd0, cdata_rd}, 32'h12345);
    chk("wr_cnt_l0_one", {19'd0, wr_cnt_l0}, 32'd1);
    chk("l0_same_cycle_old_word", {12'd0, cdata_rd}, 32'h12345);
    tick();
    chk("l0_overwrite", {12'd0, cdata_rd}, 32'h54321);
    chk("wr_cnt_l0_two", {19'd0, wr_cnt_l0}, 32'd2);

    // L1 write at the top legal address
    csel = 3'b011; caddr_wr = 12'd1023; cdata_wr = 20'h00ABC; crd = 1'b0;
    tick();
    cwr = 1'b0;
    crd = 1'b1; caddr_rd = 12'd1023;
    rb_push("rb_l1_1023", 3'b011, 12'd1023, 20'h00ABC); #1;
    chk("l1_crd_1023", {12'd0, cdata_rd}, 32'h00ABC);
    chk("wr_cnt_l1_one", {21'd0, wr_cnt_l1}, 32'd1);
    chk("sel_err_clean", {31'd0, sel_err}, 32'd0);
    tick();
    rb_pop();
    crd = 1'b0;

    // L1 address 1024 is out of range
    cwr = 1'b1; csel = 3'b011; caddr_wr = 12'd1024; cdata_wr = 20'h11111;
    tick();
    chk("sel_err_l1_oob", {31'd0, sel_err}, 32'd1);
    chk("wr_cnt_l1_after_oob", {21'd0, wr_cnt_l1}, 32'd1);

    // csel 010 is illegal for write and read
    csel = 3'b010; caddr_wr = 12'd7; crd = 1'b1; caddr_rd = 12'd4095; #1;
    chk("crd_illegal_sel_zero", {12'd0, cdata_rd}, 32'd0);
    tick();
    cwr = 1'b0;
    chk("wr_cnt_l0_after_010", {19'd0, wr_cnt_l0}, 32'd2);
    chk("wr_cnt_l1_after_010", {21'd0, wr_cnt_l1}, 32'd1);
    crd = 1'b0; csel = 3'b001; #1;
    chk("crd_low_zero", {12'd0, cdata_rd}, 32'd0);

    // busy low in RUN finishes the run
    busy = 1'b0;
    tick();
    chk("done_after_busy_low", {31'd0, done}, 32'd1);
    chk("no_timeout_normal_run", {31'd0, timeout_err}, 32'd0);

    // writes in DONE are dropped
    cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd4095; cdata_wr = 20'h0FFFF;
    tick();
    cwr = 1'b0;
    chk("wr_cnt_l0_done_drop", {19'd0, wr_cnt_l0}, 32'd2);
    rb_push("rb_l0_after_done_drop", 3'b001, 12'd4095, 20'h54321);
    tick();
    rb_pop();

    // restart clears statistics and errors
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done_low", {31'd0, done}, 32'd0);
    chk("restart_ready", {31'd0, ready}, 32'd1);
    chk("restart_cnt_l0", {19'd0, wr_cnt_l0}, 32'd0);
    chk("restart_cnt_l1", {21'd0, wr_cnt_l1}, 32'd0);
    chk("restart_sel_err", {31'd0, sel_err}, 32'd0);
    rb_push("rb_img_130", 3'b000, 12'd130, 20'd130);

    // no busy: timeout after TO cycles in ARM
    tick();
    rb_pop();
    for (int i = 2; i < int'(TO); i++) tick();
    chk("pre_timeout_ready", {31'd0, ready}, 32'd1);
    chk("pre_timeout_done", {31'd0, done}, 32'd0);
    tick();
    chk("timeout_done", {31'd0, done}, 32'd1);
    chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    chk("timeout_ready_low", {31'd0, ready}, 32'd0);

    // illegal write in DONE: dropped without error
    cwr = 1'b1; csel = 3'b010;
    tick();
    cwr = 1'b0;
    chk("done_illegal_no_err", {31'd0, sel_err}, 32'd0);

    // asynchronous reset while in RUN with a write pending
    start = 1'b1;
    tick();
    start = 1'b0; busy = 1'b1;
    tick();
    chk("run_before_reset_ready", {31'd0, ready}, 32'd0);
    cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd4095; cdata_wr = 20'h77777;
    #2 reset = 1'b1;
    #1;
    chk_reset_outputs("midrun");
    tick();
    cwr = 1'b0; busy = 1'b0;
    reset = 1'b0;
    chk("reset_held_ready", {31'd0, ready}, 32'd0);
    rb_push("rb_l0_survives_reset", 3'b001, 12'd4095, 20'h54321);
    tick();
    rb_pop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
